// File: rtl/stopwatch_core.sv
// stopwatch_core: single-clock BCD stopwatch with key edge detection, lap hold
// and a configurable overflow policy (wrap or saturate-and-stop).
module stopwatch_core #(
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned DIGITS      = 6,
  parameter bit          SEXAGESIMAL = 1'b1,
  parameter bit          WRAP        = 1'b1
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                start_stop_n,
  input  logic                lap_n,
  input  logic                clear_n,
  output logic [4*DIGITS-1:0] bcd,
  output logic                running,
  output logic                lap_active,
  output logic                overflow,
  output logic                tick
);

  localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned   CW       = 4 * DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // key bit positions inside the synchroniser vectors
  localparam int unsigned K_SS  = 0;
  localparam int unsigned K_LAP = 1;
  localparam int unsigned K_CLR = 2;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_e;

  run_e          run_q, run_d;
  logic [2:0]    sync1_q, sync2_q, prev_q;
  logic [2:0]    press;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] lap_q, lap_d;
  logic          lap_act_q, lap_act_d;
  logic          ovf_q, ovf_d;
  logic          carry, full_scale, clr, sat_stop;

  function automatic logic [3:0] digit_lim(input int unsigned idx);
    return (SEXAGESIMAL && (idx == 3)) ? 4'd5 : 4'd9;
  endfunction

  // Key synchroniser plus previous-value flop; idle level is released (1).
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {clear_n, lap_n, start_stop_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press   = ~sync2_q & prev_q;
  assign running = (run_q == ST_RUNNING);
  assign clr     = press[K_CLR] && !running;

  // Run/stop state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) run_q <= ST_STOPPED;
    else          run_q <= run_d;
  end

  // Run/stop next state: a saturating overflow overrides a coincident start press.
  always_comb begin
    run_d = run_q;
    if (press[K_SS]) run_d = (run_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    if (sat_stop)    run_d = ST_STOPPED;
  end

  // Prescaler: advances only while running, so the sub-tick fraction survives a stop.
  always_comb begin
    tick_d = running && (pre_q == PRE_LAST);
    pre_d  = pre_q;
    if (clr)          pre_d = '0;
    else if (running) pre_d = tick_d ? '0 : pre_q + PW'(1);
  end

  // BCD increment with combinational carry ripple; final carry marks full scale.
  always_comb begin
    cnt_inc = cnt_q;
    carry   = tick_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == digit_lim(i)) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    full_scale = carry;
  end

  // Count, overflow and lap next state; clear outranks increment and lap.
  always_comb begin
    cnt_d     = cnt_inc;
    ovf_d     = ovf_q;
    sat_stop  = 1'b0;
    lap_d     = lap_q;
    lap_act_d = lap_act_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (full_scale) begin
      ovf_d = 1'b1;
      if (!WRAP) begin
        cnt_d    = cnt_q;
        sat_stop = 1'b1;
      end
    end
    if (clr) begin
      lap_d     = '0;
      lap_act_d = 1'b0;
    end else if (press[K_LAP]) begin
      if (!lap_act_q) begin
        lap_d     = cnt_q;
        lap_act_d = 1'b1;
      end else begin
        lap_act_d = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      lap_q     <= '0;
      lap_act_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      lap_q     <= lap_d;
      lap_act_q <= lap_act_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bcd        = lap_act_q ? lap_q : cnt_q;
  assign lap_active = lap_act_q;
  assign overflow   = ovf_q;
  assign tick       = tick_q;

endmodule
